// File: rtl/sram_top.sv
// Serially loaded SRAM wrapper: MSB-first shift register feeds a 2**ROWS x COLS array.
// Writes land in 1 edge; reads return registered data with a 1-cycle valid pulse; no backpressure.
module sram_top #(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            serial_in,
  input  logic            shift,
  input  logic            w_en,
  input  logic            r_en,
  input  logic [ROWS-1:0] addr,
  output logic [COLS-1:0] data_out,
  output logic            data_valid
);

  localparam int DEPTH = 2 ** ROWS;

  logic [COLS-1:0] sr;
  logic [COLS-1:0] mem [DEPTH];
  logic            rd_accept;

  // A write on the same edge wins; the read is dropped entirely.
  assign rd_accept = r_en && !w_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (shift) begin
        sr <= {sr[COLS-2:0], serial_in};
      end
      // Stores the pre-shift word even when shift is asserted on this edge.
      if (w_en) begin
        mem[addr] <= sr;
      end
      data_valid <= rd_accept;
      if (rd_accept) begin
        data_out <= mem[addr];
      end
    end
  end

endmodule

// File: tb/tb_sram_top.sv
// Randomized and directed bench for sram_top with a queue-based scoreboard.
module tb_sram_top;

  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int DEPTH = 2 ** ROWS;

  logic            clk;
  logic            rst;
  logic            serial_in;
  logic            shift;
  logic            w_en;
  logic            r_en;
  logic [ROWS-1:0] addr;
  logic [COLS-1:0] data_out;
  logic            data_valid;

  sram_top #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .shift      (shift),
    .w_en       (w_en),
    .r_en       (r_en),
    .addr       (addr),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [COLS-1:0] data;
    int              cyc;
  } exp_t;

  // Reference model: memory as an array, shift register as the stream of bits received.
  logic [COLS-1:0] model_mem [DEPTH];
  bit              bits_q [$];
  logic [COLS-1:0] model_out;
  exp_t            exp_q [$];
  int              cyc_cnt;
  int              checks;
  int              errors;
  bit              mon_en;

  function automatic logic [COLS-1:0] model_sr();
    logic [COLS-1:0] v;
    int n;
    v = '0;
    n = bits_q.size();
    for (int k = 0; k < COLS; k++) begin
      if (n - 1 - k >= 0) v[k] = bits_q[n-1-k];
    end
    return v;
  endfunction

  // One clock: drive inputs, let the edge happen, then advance the model.
  // exp_override >= 0 replaces the model's read prediction with a fixed constant.
  task automatic do_cycle(input logic s, input logic si, input logic w, input logic r,
                          input logic [ROWS-1:0] a, input logic rs, input int exp_override);
    logic [COLS-1:0] cur;
    exp_t e;
    shift = s; serial_in = si; w_en = w; r_en = r; addr = a; rst = rs;
    @(posedge clk);
    cyc_cnt++;
    if (rs) begin
      for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
      bits_q.delete();
      model_out = '0;
    end else begin
      cur = model_sr();
      if (r && !w) begin
        e.data = (exp_override >= 0) ? exp_override[COLS-1:0] : model_mem[a];
        e.cyc  = cyc_cnt;
        exp_q.push_back(e);
        model_out = model_mem[a];
      end
      if (w) model_mem[a] = cur;
      if (s) bits_q.push_back(si);
    end
    #1;
    shift = 1'b0; w_en = 1'b0; r_en = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, -1);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) do_cycle(1'b1, v[k], 1'b0, 1'b0, '0, 1'b0, -1);
  endtask

  task automatic wr(input logic [ROWS-1:0] a);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, a, 1'b0, -1);
  endtask

  task automatic rd(input logic [ROWS-1:0] a, input int expv);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, a, 1'b0, expv);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a scheduled read must show valid with its data; otherwise valid is low and data holds.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (data_valid !== 1'b1 || data_out !== e.data) begin
          errors++;
          $display("FAIL read_data cyc=%0d valid=%b data_out=%h required valid=1 data=%h",
                   cyc_cnt, data_valid, data_out, e.data);
        end
      end else begin
        checks++;
        if (data_valid !== 1'b0 || data_out !== model_out) begin
          errors++;
          $display("FAIL idle_hold cyc=%0d valid=%b data_out=%h required valid=0 data=%h",
                   cyc_cnt, data_valid, data_out, model_out);
        end
      end
    end
  end

  initial begin
    logic [COLS-1:0] held;
    checks = 0; errors = 0; cyc_cnt = 0; mon_en = 1'b0;
    model_out = '0;
    for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
    shift = 0; serial_in = 0; w_en = 0; r_en = 0; addr = '0; rst = 0;

    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, -1);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1, -1);
    check("reset_data_out", {24'd0, data_out}, 32'h0);
    check("reset_valid", {31'd0, data_valid}, 32'h0);
    mon_en = 1'b1;

    rd(4'd0, 8'h00);
    rd(4'd15, 8'h00);
    idle(1);

    shift_bits(32'hA5, 8);
    wr(4'd3);
    rd(4'd3, 8'hA5);
    idle(2);

    shift_bits(32'h3C, 8);
    wr(4'd0);
    shift_bits(32'hC3, 8);
    wr(4'd15);
    rd(4'd15, 8'hC3);
    rd(4'd0, 8'h3C);
    rd(4'd3, 8'hA5);
    idle(1);

    // Simultaneous write and read: write lands, read is dropped.
    shift_bits(32'h5A, 8);
    held = data_out;
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, -1);
    check("wr_rd_valid", {31'd0, data_valid}, 32'h0);
    check("wr_rd_hold", {24'd0, data_out}, {24'd0, held});
    rd(4'd5, 8'h5A);
    idle(1);

    // Write captures pre-shift value when shift is on the same edge.
    shift_bits(32'h81, 8);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, -1);
    rd(4'd6, 8'h81);

    // Partial load discarded by reset, which also clears the previous read.
    shift_bits(32'hB, 4);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, -1);
    check("rst_after_read", {24'd0, data_out}, 32'h0);
    shift_bits(32'hFF, 8);
    wr(4'd1);
    for (int k = 0; k < DEPTH; k++) rd(k[ROWS-1:0], (k == 1) ? 8'hFF : 8'h00);
    idle(1);

    shift_bits(32'b1110000110, 10);
    wr(4'd2);
    rd(4'd2, 8'h86);
    idle(1);

    for (int k = 0; k < 600; k++) begin
      logic w, r, rs;
      w  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 79) == 0);
      do_cycle($urandom_range(0, 1), $urandom_range(0, 1), w, r,
               $urandom_range(0, DEPTH - 1), rs, -1);
    end
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
